// File: rtl/alu_mul_seq.sv
// alu_mul_seq: shift-and-add unsigned multiplier sequencer that borrows the shared alu; define ALU_MUL_OVF_EN to add the ovf output
module alu_mul_seq #(
    parameter int BUS_WIDTH = 16,
    parameter int CNT_WIDTH = 5
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [BUS_WIDTH-1:0] a,
    input  logic [BUS_WIDTH-1:0] b,
    output logic                 busy,
    output logic                 done,
    output logic [BUS_WIDTH-1:0] result,
`ifdef ALU_MUL_OVF_EN
    output logic                 ovf,
`endif
    output logic [BUS_WIDTH-1:0] alu_x,
    output logic [BUS_WIDTH-1:0] alu_y,
    output logic                 alu_zx,
    output logic                 alu_nx,
    output logic                 alu_zy,
    output logic                 alu_ny,
    output logic                 alu_f,
    output logic                 alu_no,
    input  logic [BUS_WIDTH-1:0] alu_out,
    input  logic                 alu_carry
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t               state;
    logic [BUS_WIDTH-1:0] acc, mcand, mplier;
    logic [CNT_WIDTH-1:0] cnt;
    logic                 run, last;
    assign run  = state == RUN;
    assign last = cnt == CNT_WIDTH'(BUS_WIDTH - 1);
    // Outside RUN the alu is parked on constant zero; in RUN it adds mcand or 0 to acc
    assign alu_x  = run ? acc : '0;
    assign alu_y  = run ? mcand : '0;
    assign alu_zx = ~run;
    assign alu_nx = 1'b0;
    assign alu_zy = run ? ~mplier[0] : 1'b1;
    assign alu_ny = 1'b0;
    assign alu_f  = 1'b1;
    assign alu_no = 1'b0;
    // Sequencer: accept, BUS_WIDTH add/shift steps, one-cycle done pulse
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    state  <= RUN;
                    busy   <= 1'b1;
                    mcand  <= a;
                    mplier <= b;
                    acc    <= '0;
                    cnt    <= '0;
                end
                RUN: begin
                    acc    <= alu_out;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                    if (last) begin
                        state  <= DONE;
                        done   <= 1'b1;
                        result <= alu_out;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
`ifdef ALU_MUL_OVF_EN
    logic flag, hit;
    // Product overflows when an add carries out or a set mcand bit is shifted away while multiplier bits remain
    assign hit = (alu_carry && !alu_zy) || (mcand[BUS_WIDTH-1] && |mplier[BUS_WIDTH-1:1]);
    // Sticky overflow flag, published alongside result
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            flag <= 1'b0;
            ovf  <= 1'b0;
        end else if (state == IDLE && start) begin
            flag <= 1'b0;
        end else if (run) begin
            flag <= flag | hit;
            if (last) ovf <= flag | hit;
        end
    end
`else
    logic unused_carry;
    assign unused_carry = alu_carry;
`endif
endmodule
